// File: rtl/sub_pkg.sv
// -----------------------------------------------------------------------------
// sub_pkg
// Definitions shared by the serial subtractor files:
//   - DEFAULT_WIDTH : default operand/result width in bits
//   - state_e       : controller state encoding (IDLE / RUN / DONE)
// -----------------------------------------------------------------------------
package sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage : sub_pkg

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// One-bit full subtractor computing a - b - bin. It is built from two chained
// half subtractors: the first forms a - b, and the second subtracts bin from
// that partial difference. At most one stage can borrow, so an OR is enough to
// merge the two borrows.
// Ports:
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
// -----------------------------------------------------------------------------
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic d_ab;
  logic bout_ab;
  logic bout_bin;

  half_subtractor u_hs_ab (
    .a    (a),
    .b    (b),
    .d    (d_ab),
    .bout (bout_ab)
  );

  half_subtractor u_hs_bin (
    .a    (d_ab),
    .b    (bin),
    .d    (d),
    .bout (bout_bin)
  );

  assign bout = bout_ab | bout_bin;

endmodule : full_subtractor

// File: rtl/half_subtractor.sv
// -----------------------------------------------------------------------------
// half_subtractor
// One-bit half subtractor computing a - b with no borrow input.
// Ports:
//   a    : minuend bit
//   b    : subtrahend bit
//   d    : difference bit (a ^ b)
//   bout : borrow out (set when a=0 and b=1)
// -----------------------------------------------------------------------------
module half_subtractor (
  input  logic a,
  input  logic b,
  output logic d,
  output logic bout
);

  assign d    = a ^ b;
  assign bout = ~a & b;

endmodule : half_subtractor

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial subtractor that computes a - b, starting from the least
// significant bit. It processes one bit per clock through a full subtractor
// and a registered borrow. A start/done handshake controls each operation.
// Parameters:
//   WIDTH      : operand/result width in bits (2..32)
// Ports:
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset
//   start      : request; sampled only in IDLE
//   a, b       : minuend / subtrahend; captured on the accepted start edge
//   busy       : high while an operation is shifting (RUN)
//   done       : one-cycle pulse; diff/borrow_out hold the new result
//   diff       : a - b modulo 2^WIDTH
//   borrow_out : set when a < b (unsigned underflow)
// -----------------------------------------------------------------------------
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int unsigned    CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, a_d;          // minuend shift register
  logic [WIDTH-1:0] b_q, b_d;          // subtrahend shift register
  logic [WIDTH-1:0] res_q, res_d;      // result shift register, filled from MSB
  logic             bin_q, bin_d;      // borrow carried between bits
  logic [CNT_W-1:0] cnt_q, cnt_d;      // index of the bit being processed
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_out_q, borrow_out_d;

  logic fs_d;
  logic fs_bout;
  logic last_bit;

  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (bin_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

  assign last_bit = (cnt_q == LAST_BIT);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: all flops use non-blocking assignments, so every register samples
  // the values that were current before the edge, whatever the block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: each combinational output gets a default first. This means no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    a_d          = a_q;
    b_d          = b_q;
    res_d        = res_q;
    bin_d        = bin_q;
    cnt_d        = cnt_q;
    diff_d       = diff_q;
    borrow_out_d = borrow_out_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d   = a;
          b_d   = b;
          res_d = '0;
          bin_d = 1'b0;
          cnt_d = '0;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {fs_d, res_q[WIDTH-1:1]};
        bin_d = fs_bout;
        if (last_bit) begin
          // This is the final bit. Publish the completed word together with
          // the final borrow. The counter stops at WIDTH-1 and does not wrap.
          diff_d       = {fs_d, res_q[WIDTH-1:1]};
          borrow_out_d = fs_bout;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // NOTE: the shift registers are reset along with the control flops. After
  // reset, every internal value is defined and the reset state can be
  // observed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      bin_q        <= 1'b0;
      cnt_q        <= '0;
      diff_q       <= '0;
      borrow_out_q <= 1'b0;
    end else begin
      a_q          <= a_d;
      b_q          <= b_d;
      res_q        <= res_d;
      bin_q        <= bin_d;
      cnt_q        <= cnt_d;
      diff_q       <= diff_d;
      borrow_out_q <= borrow_out_d;
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Self-checking bench for serial_subtractor with WIDTH=8. It applies a table
// of directed vectors and a set of random operand pairs. Expected results come
// from unsigned arithmetic on the operands. Hand-written sequences cover
// ignored starts, asynchronous abort and back-to-back operation.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;

  int n_vec;
  int n_err;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain unsigned arithmetic.
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    return W'(int'(x) - int'(y) + (1 << W));
  endfunction

  function automatic logic ref_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
    return (x < y);
  endfunction

  // Run one operation and check latency, busy width, result and the width of
  // the done pulse. The operands are scrambled right after the start edge.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] ed, input logic eb, input string tag);
    int  lat;
    int  busy_n;
    bit  seen;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    seen = 0; busy_n = 0; lat = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        seen = 1;
        lat  = i;
        break;
      end
      if (busy) busy_n++;
      @(posedge clk); #1;
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_latency"},   32'(lat),        32'(W));
      check({tag, "_busy_cyc"},  32'(busy_n),     32'(W));
      check({tag, "_busy_low"},  32'(busy),       32'd0);
      check({tag, "_diff"},      32'(diff),       32'(ed));
      check({tag, "_borrow"},    32'(borrow_out), 32'(eb));
      @(posedge clk); #1;
      check({tag, "_done_1cyc"}, 32'(done),       32'd0);
    end
  endtask

  vec_t vecs[6];

  initial begin
    int           done_n;
    int           last_cyc;
    int           k;
    logic [W-1:0] ra, rb;
    logic [W-1:0] bb_a[3];
    logic [W-1:0] bb_b[3];

    n_vec = 0;
    n_err = 0;
    start = 1'b0;
    a     = '0;
    b     = '0;

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
    vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[3] = '{8'hFF, 8'hFF, 8'h00, 1'b0};
    vecs[4] = '{8'h00, 8'h00, 8'h00, 1'b0};
    vecs[5] = '{8'hFF, 8'h00, 8'hFF, 1'b0};

    // Reset state.
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_busy",   32'(busy),       32'd0);
    check("rst_done",   32'(done),       32'd0);
    check("rst_diff",   32'(diff),       32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
    // rst and start together: reset wins.
    start = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_start_busy", 32'(busy), 32'd0);
    start = 1'b0;
    rst   = 1'b0;

    // Directed table.
    for (int i = 0; i < 6; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow, $sformatf("vec%0d", i));

    // Random operands against the arithmetic model.
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      do_op(ra, rb, ref_diff(ra, rb), ref_borrow(ra, rb), $sformatf("rnd%0d", i));
    end

    // The result holds through IDLE while a and b change.
    a = ~ra; b = ~rb;
    repeat (5) @(posedge clk);
    #1;
    check("hold_diff",   32'(diff),       32'(ref_diff(ra, rb)));
    check("hold_borrow", 32'(borrow_out), 32'(ref_borrow(ra, rb)));

    // A second start during RUN is ignored, as are changes to the operands.
    @(negedge clk);
    a = 8'h80; b = 8'h01; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_n = 0;
    for (int i = 0; i < 30; i++) begin
      if (i == 3) begin
        start = 1'b1; a = 8'h10; b = 8'h20;
      end else if (i == 4) begin
        start = 1'b0;
      end
      if (done) done_n++;
      @(posedge clk); #1;
    end
    check("ign_done_count", 32'(done_n),     32'd1);
    check("ign_diff",       32'(diff),       32'h7F);
    check("ign_borrow",     32'(borrow_out), 32'd0);

    // Asynchronous abort in the middle of the cycle that processes bit 4.
    @(negedge clk);
    a = 8'd9; b = 8'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy",   32'(busy),       32'd0);
    check("abort_done",   32'(done),       32'd0);
    check("abort_diff",   32'(diff),       32'd0);
    check("abort_borrow", 32'(borrow_out), 32'd0);
    done_n = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (done) done_n++;
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) done_n++;
    end
    check("abort_no_done", 32'(done_n), 32'd0);
    do_op(8'd9, 8'd4, 8'd5, 1'b0, "after_abort");

    // Back-to-back operation with start held high continuously.
    bb_a[0] = 8'h3C; bb_b[0] = 8'h11;
    bb_a[1] = 8'h01; bb_b[1] = 8'hF0;
    bb_a[2] = 8'hAA; bb_b[2] = 8'h55;
    @(negedge clk);
    a = bb_a[0]; b = bb_b[0]; start = 1'b1;
    k = 0;
    last_cyc = -1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        check($sformatf("b2b%0d_diff", k),   32'(diff),       32'(ref_diff(bb_a[k], bb_b[k])));
        check($sformatf("b2b%0d_borrow", k), 32'(borrow_out), 32'(ref_borrow(bb_a[k], bb_b[k])));
        if (last_cyc >= 0)
          check($sformatf("b2b%0d_period", k), 32'(cyc - last_cyc), 32'(W + 2));
        last_cyc = cyc;
        k++;
        if (k == 3) break;
        a = bb_a[k]; b = bb_b[k];
      end
    end
    start = 1'b0;
    check("b2b_ops", 32'(k), 32'd3);
    repeat (3) @(posedge clk);
    #1;
    check("b2b_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_serial_subtractor
